// File: rtl/fetch_queue_if.sv
// Packet type shared by fetch, the queue and decode, plus the queue's handshake interface.
package fetch_queue_pkg;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        valid;
  } if_id_packet_t;

endpackage

interface fetch_queue_if #(
  parameter int unsigned Depth = 8
);
  import fetch_queue_pkg::*;

  localparam int unsigned CntW = $clog2(Depth + 1);

  logic                  flush;
  if_id_packet_t [1:0]   if_packet_in;
  logic                  in_ready;
  if_id_packet_t [1:0]   id_packet_out;
  logic [1:0]            id_take;
  logic [CntW-1:0]       count;
  logic                  empty;
  logic                  full;

  // Fetch/decode side.
  modport master (
    output flush, if_packet_in, id_take,
    input  in_ready, id_packet_out, count, empty, full
  );

  // Queue side.
  modport slave (
    input  flush, if_packet_in, id_take,
    output in_ready, id_packet_out, count, empty, full
  );

endinterface

// File: rtl/fetch_queue.sv
// Two-wide circular instruction queue between fetch and decode.
// Takes up to two packets per cycle, presents the two oldest, flushes in one cycle.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned Depth = 8
) (
  input logic          clock,
  input logic          reset,
  fetch_queue_if.slave fq
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [CntW-1:0] InReadyMax = CntW'(Depth - 2);
  localparam logic [CntW-1:0] DepthCnt   = CntW'(Depth);

  if_id_packet_t   mem_q [Depth];
  if_id_packet_t   mem_d [Depth];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PtrW-1:0] head_p1, tail_p1;
  logic [CntW-1:0] count_q, count_d;
  logic            in_ready;
  logic [1:0]      n_in, n_acc, n_avail, n_out;

  // Only the current occupancy matters; same-cycle dequeues are not credited.
  assign in_ready = (count_q <= InReadyMax);
  assign head_p1  = head_q + PtrW'(1);
  assign tail_p1  = tail_q + PtrW'(1);

  // Pointer and occupancy registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; left unreset because count gates everything read out of it.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  // Next-state: enqueue at tail, dequeue at head, flush overrides both.
  always_comb begin
    n_in = 2'd0;
    if (fq.if_packet_in[0].valid) begin
      n_in = fq.if_packet_in[1].valid ? 2'd2 : 2'd1;
    end
    n_acc   = in_ready ? n_in : 2'd0;
    // Clamp the take to what is actually presented, so over-take is harmless.
    n_avail = (count_q >= CntW'(2)) ? 2'd2 : count_q[1:0];
    n_out   = (fq.id_take > n_avail) ? n_avail : fq.id_take;

    mem_d   = mem_q;
    head_d  = head_q + PtrW'(n_out);
    tail_d  = tail_q + PtrW'(n_acc);
    count_d = count_q + CntW'(n_acc) - CntW'(n_out);

    if (!fq.flush && (n_acc != 2'd0)) begin
      mem_d[tail_q] = fq.if_packet_in[0];
    end
    if (!fq.flush && (n_acc == 2'd2)) begin
      mem_d[tail_p1] = fq.if_packet_in[1];
    end

    if (fq.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Outputs depend on registered state only.
  always_comb begin
    fq.id_packet_out = '0;
    if (count_q != '0) begin
      fq.id_packet_out[0] = mem_q[head_q];
    end
    if (count_q > CntW'(1)) begin
      fq.id_packet_out[1] = mem_q[head_p1];
    end
    fq.in_ready = in_ready;
    fq.count    = count_q;
    fq.empty    = (count_q == '0);
    fq.full     = (count_q == DepthCnt);
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic,
// all checked against a queue-based reference model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int unsigned Depth = 8;

  logic clock;
  logic reset;

  fetch_queue_if #(.Depth(Depth)) fq ();

  fetch_queue #(.Depth(Depth)) dut (
    .clock (clock),
    .reset (reset),
    .fq    (fq)
  );

  int            n_total;
  int            n_bad;
  if_id_packet_t model_q[$];
  if_id_packet_t hold_pkt [2];
  int            hold_n;
  logic [31:0]   next_pc;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic if_id_packet_t make_pkt();
    if_id_packet_t p;
    p.inst  = $urandom();
    p.pc    = next_pc;
    p.npc   = next_pc + 32'd4;
    p.valid = 1'b1;
    next_pc = next_pc + 32'd4;
    return p;
  endfunction

  task automatic drive_idle();
    fq.if_packet_in = '0;
    fq.id_take      = 2'd0;
    fq.flush        = 1'b0;
  endtask

  // Compare every DUT output against the reference queue.
  task automatic check_outputs(input string tag);
    int            sz;
    if_id_packet_t e0, e1;
    sz = model_q.size();
    e0 = '0;
    e1 = '0;
    if (sz > 0) e0 = model_q[0];
    if (sz > 1) e1 = model_q[1];
    check({tag, ".count"},    128'(fq.count),            128'(sz));
    check({tag, ".empty"},    128'(fq.empty),            128'(sz == 0));
    check({tag, ".full"},     128'(fq.full),             128'(sz == int'(Depth)));
    check({tag, ".in_ready"}, 128'(fq.in_ready),         128'((int'(Depth) - sz) >= 2));
    check({tag, ".out0"},     128'(fq.id_packet_out[0]), 128'(e0));
    check({tag, ".out1"},     128'(fq.id_packet_out[1]), 128'(e1));
  endtask

  // One clock cycle: drive, check current outputs, advance model, cross the edge.
  task automatic step(input string tag, input int n_req, input int take, input bit fl);
    if_id_packet_t p0, p1;
    int            n, n_out, sz;
    bit            acc;
    if (hold_n > 0) begin
      n  = hold_n;
      p0 = hold_pkt[0];
      p1 = hold_pkt[1];
    end else begin
      n       = n_req;
      p0      = '0;
      p1      = '0;
      p1.inst = $urandom();
      if (n >= 1) p0 = make_pkt();
      if (n == 2) p1 = make_pkt();
    end
    fq.if_packet_in[0] = p0;
    fq.if_packet_in[1] = p1;
    fq.id_take         = 2'(take);
    fq.flush           = fl;
    check_outputs(tag);

    sz = model_q.size();
    if (fl) begin
      model_q.delete();
      hold_n = 0;
    end else begin
      acc   = (int'(Depth) - sz) >= 2;
      n_out = (take < sz) ? take : sz;
      repeat (n_out) void'(model_q.pop_front());
      if (acc) begin
        if (n >= 1) model_q.push_back(p0);
        if (n == 2) model_q.push_back(p1);
        hold_n = 0;
      end else begin
        // Fetch holds refused packets and re-offers them.
        hold_n      = n;
        hold_pkt[0] = p0;
        hold_pkt[1] = p1;
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    int take, n;
    bit fl;
    n_total = 0;
    n_bad   = 0;
    hold_n  = 0;
    next_pc = 32'h0;
    reset   = 1'b0;
    drive_idle();
    repeat (2) @(posedge clock);
    #1;
    check_outputs("reset");
    check("reset.v0", 128'(fq.id_packet_out[0].valid), 128'(0));
    check("reset.v1", 128'(fq.id_packet_out[1].valid), 128'(0));
    @(negedge clock);
    reset = 1'b1;

    // Fill to full with two-packet enqueues.
    repeat (4) step("fill", 2, 0, 1'b0);
    check("fill.count",    128'(fq.count),                 128'(8));
    check("fill.full",     128'(fq.full),                  128'(1));
    check("fill.in_ready", 128'(fq.in_ready),              128'(0));
    check("fill.pc0",      128'(fq.id_packet_out[0].pc),   128'(32'h00));
    check("fill.pc1",      128'(fq.id_packet_out[1].pc),   128'(32'h04));

    // Drain two per cycle.
    for (int i = 0; i < 4; i++) begin
      check("drain.pc0", 128'(fq.id_packet_out[0].pc), 128'(32'(i * 8)));
      check("drain.pc1", 128'(fq.id_packet_out[1].pc), 128'(32'(i * 8 + 4)));
      step("drain", 0, 2, 1'b0);
    end
    check("drain.empty", 128'(fq.empty),                  128'(1));
    check("drain.v0",    128'(fq.id_packet_out[0].valid), 128'(0));
    check("drain.v1",    128'(fq.id_packet_out[1].valid), 128'(0));

    // Steady two-in/two-out stream; the first take hits an empty queue.
    repeat (20) step("stream", 2, 2, 1'b0);
    check("stream.count", 128'(fq.count), 128'(2));

    // Single-packet traffic walks both pointers through the wrap.
    repeat (2 * Depth + 3) step("odd", 1, 1, 1'b0);

    // Flush with concurrent enqueue and dequeue.
    step("pre_flush", 0, 0, 1'b1);
    step("load5", 2, 0, 1'b0);
    step("load5", 2, 0, 1'b0);
    step("load5", 1, 0, 1'b0);
    check("load5.count", 128'(fq.count), 128'(5));
    step("flush", 2, 2, 1'b1);
    check("flush.count",    128'(fq.count),                  128'(0));
    check("flush.in_ready", 128'(fq.in_ready),               128'(1));
    check("flush.v0",       128'(fq.id_packet_out[0].valid), 128'(0));
    next_pc = 32'h100;
    step("post_flush", 1, 0, 1'b0);
    check("post_flush.pc0", 128'(fq.id_packet_out[0].pc),    128'(32'h100));
    check("post_flush.v0",  128'(fq.id_packet_out[0].valid), 128'(1));

    // Asynchronous reset mid-cycle with six entries.
    step("load6", 2, 0, 1'b0);
    step("load6", 2, 0, 1'b0);
    step("load6", 1, 0, 1'b0);
    check("load6.count", 128'(fq.count), 128'(6));
    #2;
    reset = 1'b0;
    drive_idle();
    #1;
    model_q.delete();
    hold_n = 0;
    check_outputs("async_rst");
    check("async_rst.in_ready", 128'(fq.in_ready), 128'(1));
    @(negedge clock);
    reset = 1'b1;

    // Full queue: two-packet take with attempted enqueue leaves Depth-2.
    repeat (4) step("refill", 2, 0, 1'b0);
    check("refill.full", 128'(fq.full), 128'(1));
    step("full_edge", 2, 2, 1'b0);
    check("full_edge.count", 128'(fq.count), 128'(Depth - 2));

    // Random traffic; decode never takes more than is presented.
    for (int i = 0; i < 400; i++) begin
      n    = $urandom_range(0, 2);
      take = $urandom_range(0, 2);
      if (take > model_q.size()) take = model_q.size();
      fl   = ($urandom_range(0, 31) == 0);
      step("rand", n, take, fl);
    end
    drive_idle();
    check_outputs("final");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
